versat_run_ctrl: RTL and testbench

VERSAT_RUN_CTRL -- requirements
Module: versat_run_ctrl

---
 rtl/versat_run_ctrl.sv | 130 +++++++++++++
 tb/tb_versat_run_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/versat_run_ctrl.sv
// versat_run_ctrl: run sequencer for a datapath.
// Constants are double-buffered. Host writes go to a shadow bank, which is
// copied into the active bank on the COMMIT cycle of each run. The controller
// issues a one-cycle run pulse, then waits for unit_done or for an optional
// cycle timeout, and reports the result.
module versat_run_ctrl #(
  parameter int DATA_W    = 32,
  parameter int NUM_CONST = 4,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  input  logic [$clog2(NUM_CONST)-1:0] cfg_addr,
  input  logic [DATA_W-1:0]            cfg_data,
  output logic                         cfg_ready,
  input  logic                         start,
  input  logic [CNT_W-1:0]             run_len,
  input  logic                         abort,
  input  logic                         unit_done,
  output logic                         run,
  output logic [NUM_CONST*DATA_W-1:0]  const_out,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic [CNT_W-1:0]             cycle_count
);

  localparam int               ADDR_W  = $clog2(NUM_CONST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {ST_IDLE, ST_COMMIT, ST_RUN, ST_WAIT, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q;        // run_len captured when the run is accepted
  logic [CNT_W-1:0] cnt_q;        // remaining cycles before timeout
  logic [CNT_W-1:0] cyc_q;        // cycles spent in WAIT, saturating
  logic             timeout_q;
  logic             ready_q;      // low while in reset and for the release edge
  logic             wait_expire;  // WAIT leaving because the counter ran out
  logic             wr_en;
  logic             commit_en;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic. Abort beats completion, and completion beats timeout.
  always_comb begin
    state_d     = state_q;
    wait_expire = 1'b0;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_COMMIT;
      ST_COMMIT: state_d = abort ? ST_IDLE : ST_RUN;
      ST_RUN:    state_d = abort ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (unit_done) begin
          state_d = ST_DONE;
        end else if (len_q != '0 && cnt_q == CNT_ONE) begin
          state_d     = ST_DONE;
          wait_expire = 1'b1;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Counters and result flags. Results persist until the next RUN clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q     <= '0;
      cnt_q     <= '0;
      cyc_q     <= '0;
      timeout_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (state_q == ST_IDLE && start) len_q <= run_len;
      if (state_q == ST_RUN) begin
        cnt_q     <= len_q;
        cyc_q     <= '0;
        timeout_q <= 1'b0;
      end
      if (state_q == ST_WAIT) begin
        if (cyc_q != CNT_MAX) cyc_q <= cyc_q + CNT_ONE;
        if (cnt_q != '0)      cnt_q <= cnt_q - CNT_ONE;
        if (state_d == ST_DONE) timeout_q <= wait_expire;
      end
    end
  end

  assign cfg_ready = ready_q && (state_q != ST_COMMIT);
  assign wr_en     = cfg_valid && cfg_ready;
  assign commit_en = (state_q == ST_COMMIT) && !abort;

  // Each slot keeps its own shadow and active registers. An aborted COMMIT
  // leaves the active copy untouched.
  generate
    for (genvar gi = 0; gi < NUM_CONST; gi++) begin : g_slot
      logic [DATA_W-1:0] shadow_q;
      logic [DATA_W-1:0] active_q;

      // Shadow write from the host and shadow-to-active transfer on commit.
      always_ff @(posedge clk) begin
        if (!rst) begin
          shadow_q <= '0;
          active_q <= '0;
        end else begin
          if (wr_en && cfg_addr == ADDR_W'(gi)) shadow_q <= cfg_data;
          if (commit_en) active_q <= shadow_q;
        end
      end

      assign const_out[gi*DATA_W +: DATA_W] = active_q;
    end
  endgenerate

  assign run         = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign timeout     = timeout_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_versat_run_ctrl.sv
// Testbench for versat_run_ctrl.
// A table of runs is applied, and expected completions go to a scoreboard
// queue. Hand-written sequences cover abort, ignored start and mid-run reset.
module tb_versat_run_ctrl;

  logic         clk;
  logic         rst;
  logic         cfg_valid;
  logic [1:0]   cfg_addr;
  logic [31:0]  cfg_data;
  logic         cfg_ready;
  logic         start;
  logic [15:0]  run_len;
  logic         abort;
  logic         unit_done;
  logic         run;
  logic [127:0] const_out;
  logic         busy;
  logic         done;
  logic         timeout;
  logic [15:0]  cycle_count;

  versat_run_ctrl #(.DATA_W(32), .NUM_CONST(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .start(start), .run_len(run_len), .abort(abort), .unit_done(unit_done),
    .run(run), .const_out(const_out), .busy(busy), .done(done),
    .timeout(timeout), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned len;      // run_len
    int          done_at;  // WAIT cycle in which unit_done is raised, 0 = never
    bit          cw;       // attempt a shadow write during COMMIT
    bit          ww;       // shadow write in the first WAIT cycle
    bit          exp_to;
    int unsigned exp_cyc;
  } vec_t;

  typedef struct {
    int unsigned edge_n;
    bit          to;
    int unsigned cyc;
  } sb_t;

  sb_t         sb[$];
  vec_t        vecs[7];
  logic [31:0] sh[4];
  logic [31:0] act[4];
  int          total = 0;
  int          bad = 0;
  int unsigned edges = 0;
  int unsigned run_pulses = 0;
  bit          done_seen = 0;

  task automatic chk(input string nm, input logic [127:0] act_v, input logic [127:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", nm, act_v, exp_v);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event not seen as required", nm);
  endtask

  function automatic logic [127:0] pack_act();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = act[i];
    return r;
  endfunction

  // Advance one clock, sample 1ns later, and retire any completed run.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    edges++;
    if (run === 1'b1) run_pulses++;
    if (done === 1'b1) begin
      done_seen = 1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got=1 required=0 at edge %0d", edges);
      end else begin
        e = sb.pop_front();
        chk("done_edge", edges, e.edge_n);
        chk("timeout", timeout, e.to);
        chk("cycle_count", cycle_count, e.cyc);
        $display("run retired at edge %0d timeout=%0d cycle_count=%0d", edges, timeout, cycle_count);
      end
    end
  endtask

  task automatic cfg_write(input int a, input logic [31:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = 2'(a);
    cfg_data  = d;
    chk("cfg_ready_idle", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    sh[a] = d;
    $display("cfg write slot %0d = %0h", a, d);
  endtask

  task automatic do_run(input vec_t v);
    int unsigned t0;
    int unsigned rp;
    sb_t         e;
    rp = run_pulses;
    start   = 1'b1;
    run_len = 16'(v.len);
    tick();
    start = 1'b0;
    t0 = edges;
    e.edge_n = t0 + 2 + v.exp_cyc;
    e.to     = v.exp_to;
    e.cyc    = v.exp_cyc;
    sb.push_back(e);
    // COMMIT cycle
    chk("commit_busy", busy, 1);
    chk("commit_run", run, 0);
    chk("commit_ready", cfg_ready, 0);
    if (v.cw) begin
      cfg_valid = 1'b1;
      cfg_addr  = 2'd2;
      cfg_data  = 32'h55;
    end
    for (int i = 0; i < 4; i++) act[i] = sh[i];
    tick();
    // RUN cycle
    chk("run_pulse", run, 1);
    chk("run_const", const_out, pack_act());
    chk("run_ready", cfg_ready, 1);
    tick();
    if (v.cw) begin
      cfg_valid = 1'b0;
      sh[2] = 32'h55;
    end
    done_seen = 0;
    for (int k = 1; k <= 64 && !done_seen; k++) begin
      unit_done = (k == v.done_at);
      if (v.ww && k == 1) begin
        cfg_valid = 1'b1;
        cfg_addr  = 2'd1;
        cfg_data  = 32'hAA;
      end
      tick();
      if (v.ww && k == 1) begin
        cfg_valid = 1'b0;
        sh[1] = 32'hAA;
      end
      chk("const_hold", const_out, pack_act());
    end
    unit_done = 1'b0;
    if (!done_seen) fail_now("done_bound");
    tick();
    // back in IDLE: results held
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("hold_timeout", timeout, v.exp_to);
    chk("hold_cycles", cycle_count, v.exp_cyc);
    chk("run_count", run_pulses - rp, 1);
    $display("run len=%0d done_at=%0d finished", v.len, v.done_at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{len: 0, done_at: 5, cw: 0, ww: 0, exp_to: 0, exp_cyc: 5};
    vecs[1] = '{len: 3, done_at: 0, cw: 0, ww: 0, exp_to: 1, exp_cyc: 3};
    vecs[2] = '{len: 2, done_at: 2, cw: 1, ww: 0, exp_to: 0, exp_cyc: 2};
    vecs[3] = '{len: 1, done_at: 0, cw: 0, ww: 1, exp_to: 1, exp_cyc: 1};
    vecs[4] = '{len: 4, done_at: 1, cw: 0, ww: 0, exp_to: 0, exp_cyc: 1};
    vecs[5] = '{len: 5, done_at: 7, cw: 0, ww: 0, exp_to: 1, exp_cyc: 5};
    vecs[6] = '{len: 0, done_at: 1, cw: 0, ww: 0, exp_to: 0, exp_cyc: 1};
    for (int i = 0; i < 4; i++) begin
      sh[i]  = '0;
      act[i] = '0;
    end

    rst = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; run_len = '0; abort = 1'b0; unit_done = 1'b0;
    tick();
    tick();
    chk("rst_run", run, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_const", const_out, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cycles", cycle_count, 0);
    rst = 1'b1;
    tick();
    chk("rel_ready", cfg_ready, 1);

    cfg_write(0, 32'h11);
    cfg_write(1, 32'h22);
    cfg_write(2, 32'h33);
    cfg_write(3, 32'h44);

    for (int i = 0; i < 7; i++) do_run(vecs[i]);

    // Abort during COMMIT keeps the old active constants.
    cfg_write(0, 32'h77);
    start = 1'b1; run_len = 16'd2;
    tick();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_commit_busy", busy, 0);
    chk("abort_commit_const", const_out, pack_act());
    tick();
    chk("abort_commit_idle", busy, 0);
    $display("abort in COMMIT done");

    // A second start during WAIT is ignored, and abort in WAIT 2 gives no done.
    start = 1'b1; run_len = 16'd0;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; run_len = 16'd5;
    tick();
    start = 1'b0;
    chk("wait2_busy", busy, 1);
    chk("wait2_done", done, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_run", run, 0);
    tick();
    chk("ignored_start", busy, 0);
    $display("abort in WAIT done");

    // Reset in the middle of WAIT.
    start = 1'b1; run_len = 16'd0;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      sh[i]  = '0;
      act[i] = '0;
    end
    chk("mid_rst_run", run, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cfg_ready, 0);
    chk("mid_rst_const", const_out, 0);
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_cycles", cycle_count, 0);
    tick();
    chk("mid_rst_hold_ready", cfg_ready, 0);
    rst = 1'b1;
    tick();
    chk("post_rst_ready", cfg_ready, 1);
    chk("post_rst_const", const_out, pack_act());
    chk("post_rst_busy", busy, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("post_rst_done", done, 0);
    chk("sb_empty", sb.size(), 0);
    $display("reset mid WAIT done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
